// File: rtl/ram_bus_pkg.sv
// Shared widths and FSM encodings for the single-port RAM master.
// Imported by the interface and the master.
package ram_bus_pkg;

  localparam int RAM_ADDR_W = 4;
  localparam int RAM_DATA_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_TURN = 2'd3;

endpackage

// File: rtl/single_port_ram_master_if.sv
// Client-side command, write-stream and read-stream bundle.
// master = the client issuing bursts, slave = the RAM master.
interface single_port_ram_master_if
  import ram_bus_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              busy;

  modport master (
    output cmd_valid, cmd_we, cmd_addr,
    output cmd_len, wr_valid, wr_data,
    input  cmd_ready, wr_ready, rd_valid,
    input  rd_data, rd_last, busy
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr,
    input  cmd_len, wr_valid, wr_data,
    output cmd_ready, wr_ready, rd_valid,
    output rd_data, rd_last, busy
  );

endinterface

// File: rtl/single_port_ram_master.sv
// Burst initiator for the 16x8 single-port RAM with shared data bus.
// RAM_MASTER_TURNAROUND_EN adds one dead TURN cycle after reads.
module single_port_ram_master
  import ram_bus_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  single_port_ram_master_if.slave cl,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_we,
  output logic                 ram_re,
  inout  wire  [DATA_W-1:0]    ram_data
);

  localparam logic [ADDR_W:0] CNT_ONE =
    {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic              r_re;
  logic              r_re_d;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic [DATA_W-1:0] r_rd_data;

  logic w_idle;
  logic w_wr;
  logic w_rd;
  logic w_cnt_zero;
  logic w_cnt_last;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_wr       = (r_state == ST_WR);
  assign w_rd       = (r_state == ST_RD);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_last = (r_cnt == CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_re_d     <= 1'b0;
      r_wdata    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_re_d     <= r_re;
      r_we       <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      unique case (1'b1)
        w_idle: begin
          if (cl.cmd_valid) begin
            r_ptr <= cl.cmd_addr;
            r_cnt <= {1'b0, cl.cmd_len} + 1'b1;
            if (cl.cmd_we) begin
              r_state <= ST_WR;
            end else begin
              r_state <= ST_RD;
              r_re    <= 1'b1;
              r_addr  <= cl.cmd_addr;
            end
          end
        end
        w_wr: begin
          if (cl.wr_valid) begin
            r_we    <= 1'b1;
            r_wdata <= cl.wr_data;
            r_addr  <= r_ptr;
            r_ptr   <= r_ptr + 1'b1;
            r_cnt   <= r_cnt - 1'b1;
            if (w_cnt_last) r_state <= ST_IDLE;
          end
        end
        w_rd: begin
          // RAM output lags ram_re by one cycle
          if (r_re_d) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= ram_data;
            r_rd_last  <= w_cnt_zero;
          end
          if (w_cnt_zero) begin
            r_re <= 1'b0;
`ifdef RAM_MASTER_TURNAROUND_EN
            r_state <= ST_TURN;
`else
            r_state <= ST_IDLE;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (!w_cnt_last) r_addr <= r_addr + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cl.cmd_ready = w_idle;
  assign cl.wr_ready  = w_wr;
  assign cl.busy      = !w_idle;
  assign cl.rd_valid  = r_rd_valid;
  assign cl.rd_data   = r_rd_data;
  assign cl.rd_last   = r_rd_last;

  assign ram_addr = r_addr;
  assign ram_we   = r_we;
  assign ram_re   = r_re;
  assign ram_data = r_we ? r_wdata : 'z;

endmodule

// File: tb/tb_single_port_ram_master.sv
// Directed bench for single_port_ram_master with a registered RAM model.
// Honours RAM_MASTER_TURNAROUND_EN for the post-read timing.
module tb_single_port_ram_master;

`ifdef RAM_MASTER_TURNAROUND_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] ram_addr;
  logic       ram_we;
  logic       ram_re;
  wire  [7:0] ram_data;

  single_port_ram_master_if bus ();

  single_port_ram_master dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cl       (bus),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_re   (ram_re),
    .ram_data (ram_data)
  );

  logic [7:0] mem     [16] = '{default: 8'h00};
  logic [7:0] exp_mem [16] = '{default: 8'h00};
  logic [7:0] wdat    [16];
  logic [7:0] m_q = 8'h00;
  logic       m_oe = 1'b0;
  logic       contention = 1'b0;
  int         ncmp = 0;
  int         nerr = 0;
  int         waited;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: registered read, drives the bus only while ram_re is high
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    if (ram_re) m_q <= mem[ram_addr];
    m_oe <= ram_re;
  end
  assign ram_data = (m_oe && ram_re) ? m_q : 8'hzz;

  always @(negedge clk)
    if (rst_n && ram_we && ram_re) contention <= 1'b1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got 0x%0h want 0x%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic bus_idle();
    return (ram_data === 8'hzz) || (ram_data === 8'h00);
  endfunction

  task automatic do_write(input logic [3:0] a,
                          input logic [3:0] len,
                          input logic [31:0] vpat,
                          output int wt);
    int beat;
    int i;
    int n;
    logic hs;
    logic [3:0] ea;
    n = int'(len) + 1;
    beat = 0;
    i = 0;
    wt = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = len;
    while (!bus.cmd_ready && wt < 8) begin
      tick();
      wt++;
    end
    chk("wr_accept", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("wr_busy", {bus.busy, bus.cmd_ready}, 2'b10);
    while (beat < n && i < 32) begin
      ea = a + beat[3:0];
      hs = vpat[i];
      bus.wr_valid = hs;
      bus.wr_data  = wdat[beat];
      chk("wr_ready", bus.wr_ready, 1);
      tick();
      chk("wr_we", ram_we, hs);
      chk("wr_no_re", ram_re, 0);
      if (hs) begin
        chk("wr_addr", ram_addr, ea);
        chk("wr_data", ram_data, wdat[beat]);
        exp_mem[ea] = wdat[beat];
        beat++;
      end else begin
        chk("wr_stall_z", bus_idle(), 1);
      end
      i++;
    end
    bus.wr_valid = 1'b0;
    chk("wr_beats", beat, n);
    chk("wr_end_idle", bus.cmd_ready, 1);
    tick();
    chk("wr_end_we", ram_we, 0);
    chk("wr_end_z", bus_idle(), 1);
  endtask

  task automatic do_read(input logic [3:0] a,
                         input logic [3:0] len);
    int n;
    int off;
    logic [3:0] ea;
    n = int'(len) + 1;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = a;
    bus.cmd_len   = len;
    chk("rd_accept", bus.cmd_ready, 1);
    for (int k = 1; k <= n + 2; k++) begin
      tick();
      bus.cmd_valid = 1'b0;
      off = (k - 1 < n - 1) ? k - 1 : n - 1;
      ea = a + off[3:0];
      chk("rd_re", ram_re, k <= n + 1);
      chk("rd_no_we", ram_we, 0);
      if (k <= n + 1) chk("rd_addr", ram_addr, ea);
      chk("rd_valid", bus.rd_valid, k >= 3);
      if (k >= 3) begin
        ea = a + 4'(k - 3);
        chk("rd_data", bus.rd_data, exp_mem[ea]);
        chk("rd_last", bus.rd_last, k == n + 2);
      end
      chk("rd_cmd_ready", bus.cmd_ready,
          (k == n + 2) && !TE);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    tick();
    tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_last", bus.rd_last, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_we_re", {ram_we, ram_re}, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_z", bus_idle(), 1);
    rst_n = 1'b1;
    tick();

    // reset in C2 of a read burst
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 4'd0;
    bus.cmd_len   = 4'd3;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("abort_pre_re", ram_re, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_re", ram_re, 0);
    chk("abort_rd_valid", bus.rd_valid, 0);
    chk("abort_z", bus_idle(), 1);
    chk("abort_cmd_ready", bus.cmd_ready, 1);
    chk("abort_busy", bus.busy, 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("abort_no_last", {bus.rd_last, bus.rd_valid}, 0);
      chk("abort_idle", bus.cmd_ready, 1);
    end

    // single beat write/read at 3
    wdat[0] = 8'hA5;
    do_write(4'd3, 4'd0, 32'hFFFF_FFFF, waited);
    do_read(4'd3, 4'd0);
    tick();
    tick();
    chk("mem3", mem[3], 8'hA5);

    // wrapping 4-beat burst at 14
    wdat[0] = 8'h11;
    wdat[1] = 8'h22;
    wdat[2] = 8'h33;
    wdat[3] = 8'h44;
    do_write(4'd14, 4'd3, 32'hFFFF_FFFF, waited);
    chk("mem14", mem[14], 8'h11);
    chk("mem15", mem[15], 8'h22);
    chk("mem0", mem[0], 8'h33);
    chk("mem1", mem[1], 8'h44);
    do_read(4'd14, 4'd3);
    tick();
    tick();

    // write with wr_valid gaps 1,0,0,1,0,1
    wdat[0] = 8'h5A;
    wdat[1] = 8'h6B;
    wdat[2] = 8'h7C;
    do_write(4'd5, 4'd2, 32'h0000_0029, waited);
    chk("gap_mem7", mem[7], 8'h7C);
    do_read(4'd5, 4'd2);
    tick();
    tick();

    // read immediately followed by write
    do_read(4'd3, 4'd0);
    wdat[0] = 8'h9E;
    do_write(4'd8, 4'd0, 32'hFFFF_FFFF, waited);
    chk("turn_wait", waited, TE ? 1 : 0);
    chk("mem8", mem[8], 8'h9E);

    // full 16-beat burst
    for (int i = 0; i < 16; i++) wdat[i] = 8'h80 + 8'(i);
    do_write(4'd0, 4'd15, 32'hFFFF_FFFF, waited);
    do_read(4'd0, 4'd15);
    tick();
    tick();
    chk("full_idle", bus.cmd_ready, 1);

    chk("no_contention", contention, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
